// File: rtl/fc_input_loader.sv
// Loads IP_LAYER1_SIZE feature words from RAM (one read per cycle) into a local buffer.
// Start-to-valid latency is N+2 cycles, and en_fc holds until fc_ack arrives; no stalls are supported.
module fc_input_loader #(
    parameter int WORD_SIZE      = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int IP_LAYER1_SIZE = 128
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cnnDone,
    input  logic [ADDR_WIDTH-1:0]               base_addr,
    output logic                                ram_rd_en,
    output logic [ADDR_WIDTH-1:0]               ram_addr,
    input  logic [WORD_SIZE-1:0]                ram_rdata,
    output logic                                busy,
    output logic                                en_fc,
    input  logic                                fc_ack,
    output logic [WORD_SIZE*IP_LAYER1_SIZE-1:0] X_flat
);

    localparam int CW = $clog2(IP_LAYER1_SIZE + 1);
    localparam logic [CW-1:0]         LAST_IDX = CW'(IP_LAYER1_SIZE - 1);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                              state_q;
    logic                                rd_en_q;
    logic [ADDR_WIDTH-1:0]               addr_q;
    logic                                busy_q;
    logic                                en_fc_q;
    logic [CW-1:0]                       issue_q;
    logic                                cap_vld_q;
    logic [CW-1:0]                       cap_idx_q;
    logic [WORD_SIZE*IP_LAYER1_SIZE-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            en_fc_q   <= 1'b0;
            issue_q   <= '0;
            cap_vld_q <= 1'b0;
            cap_idx_q <= '0;
        end else begin
            // Capture pipeline trails the issue side by exactly one cycle (RAM latency).
            cap_vld_q <= rd_en_q;
            cap_idx_q <= issue_q;
            case (state_q)
                IDLE: begin
                    if (cnnDone) begin
                        state_q <= READ;
                        rd_en_q <= 1'b1;
                        addr_q  <= base_addr;
                        issue_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                READ: begin
                    if (issue_q == LAST_IDX) begin
                        state_q <= DRAIN;
                        rd_en_q <= 1'b0;
                    end else begin
                        issue_q <= issue_q + CNT_ONE;
                        addr_q  <= addr_q + ADDR_ONE;
                    end
                end
                DRAIN: begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    en_fc_q <= 1'b1;
                end
                DONE: begin
                    if (fc_ack) begin
                        state_q <= IDLE;
                        en_fc_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Buffer is not reset; X_flat gating hides stale contents, and reset blocks in-flight capture.
    always_ff @(posedge clk) begin
        if (!rst && cap_vld_q) begin
            for (int i = 0; i < IP_LAYER1_SIZE; i++) begin
                if (cap_idx_q == CW'(i)) begin
                    data_q[i*WORD_SIZE +: WORD_SIZE] <= ram_rdata;
                end
            end
        end
    end

    assign ram_rd_en = rd_en_q;
    assign ram_addr  = addr_q;
    assign busy      = busy_q;
    assign en_fc     = en_fc_q;
    assign X_flat    = en_fc_q ? data_q : '0;

endmodule

// File: tb/tb_fc_input_loader.sv
// Directed bench: a 128-word loader driven by a table of loads, plus a 1-word loader for the minimum size.
module tb_fc_input_loader;
    localparam int N = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cnn0 = 1'b0, ack0 = 1'b0, cnn1 = 1'b0, ack1 = 1'b0;
    logic [15:0] base0 = '0, base1 = '0;
    logic        rd0, rd1, busy0, busy1, en0, en1;
    logic [15:0] addr0, addr1;
    logic [15:0] rdata0 = '0, rdata1 = '0;
    logic [16*N-1:0] x0;
    logic [15:0]     x1;
    int mode = 0;
    int total = 0;
    int passed = 0;

    fc_input_loader #(.WORD_SIZE(16), .ADDR_WIDTH(16), .IP_LAYER1_SIZE(N)) dut0 (
        .clk(clk), .rst(rst), .cnnDone(cnn0), .base_addr(base0), .ram_rd_en(rd0),
        .ram_addr(addr0), .ram_rdata(rdata0), .busy(busy0), .en_fc(en0), .fc_ack(ack0), .X_flat(x0));

    fc_input_loader #(.WORD_SIZE(16), .ADDR_WIDTH(16), .IP_LAYER1_SIZE(1)) dut1 (
        .clk(clk), .rst(rst), .cnnDone(cnn1), .base_addr(base1), .ram_rd_en(rd1),
        .ram_addr(addr1), .ram_rdata(rdata1), .busy(busy1), .en_fc(en1), .fc_ack(ack1), .X_flat(x1));

    always #5 clk = ~clk;

    function automatic logic [15:0] ram_f(logic [15:0] a);
        return (mode == 0) ? (a ^ 16'h5A5A) : ~a;
    endfunction

    // One-cycle-latency RAM model.
    always @(posedge clk) begin
        if (rd0) rdata0 <= ram_f(addr0);
        if (rd1) rdata1 <= ram_f(addr1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int word_errs(input logic [15:0] base);
        int e = 0;
        logic [15:0] a = base;
        for (int i = 0; i < N; i++) begin
            if (x0[i*16 +: 16] != ram_f(a)) e++;
            a = a + 16'd1;
        end
        return e;
    endfunction

    // Pulse cnnDone in cycle t, then observe cycles t+1..t+N+4 (ends in DONE, unacked).
    task automatic run_load(input logic [15:0] base, input bit repulse,
                            output int nreads, output int addr_err,
                            output int en_cycle, output int busy_err);
        logic [15:0] ea = base;
        nreads = 0; addr_err = 0; en_cycle = 0; busy_err = 0;
        @(negedge clk);
        base0 = base;
        cnn0  = 1'b1;
        for (int c = 1; c <= N + 4; c++) begin
            @(negedge clk);
            cnn0 = repulse && (c == 5 || c == N + 2);
            if (c == 3) base0 = ~base;
            if (rd0) begin
                nreads++;
                if (addr0 != ea) addr_err++;
                ea = ea + 16'd1;
            end
            if (en0 && en_cycle == 0) en_cycle = c;
            if (busy0 != (c <= N + 1)) busy_err++;
        end
        cnn0 = 1'b0;
    endtask

    task automatic do_ack(input string tag, input bit with_start);
        int extra = 0;
        @(negedge clk);
        ack0 = 1'b1;
        cnn0 = with_start;
        @(negedge clk);
        ack0 = 1'b0;
        cnn0 = 1'b0;
        check({tag, "_en_after_ack"}, en0, 0);
        check({tag, "_x_zero_after_ack"}, (x0 == '0), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rd0 || busy0) extra++;
        end
        check({tag, "_idle_after_ack"}, extra, 0);
    endtask

    typedef struct {
        logic [15:0] base;
        int          mode;
        bit          repulse;
        int          idx;
        logic [15:0] exp_word;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int nr, ae, ec, be;
        logic [16*N-1:0] snap;
        int changes;

        vecs[0] = '{16'h0100, 0, 1'b0, 0,   16'h5B5A};
        vecs[1] = '{16'h0100, 0, 1'b0, 127, 16'h5B25};
        vecs[2] = '{16'hFFF0, 0, 1'b0, 16,  16'h5A5A};
        vecs[3] = '{16'h0100, 0, 1'b1, 5,   16'h5B5F};
        vecs[4] = '{16'h1234, 1, 1'b0, 0,   16'hEDCB};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_rd_en", rd0, 0);
        check("rst_addr", addr0, 0);
        check("rst_busy", busy0, 0);
        check("rst_en_fc", en0, 0);
        check("rst_x_zero", (x0 == '0), 1);
        check("rst_n1_en_fc", en1, 0);

        for (int v = 0; v < 5; v++) begin
            string t;
            t = $sformatf("vec%0d", v);
            mode = vecs[v].mode;
            run_load(vecs[v].base, vecs[v].repulse, nr, ae, ec, be);
            check({t, "_nreads"}, nr, N);
            check({t, "_addr_seq"}, ae, 0);
            check({t, "_en_latency"}, ec, N + 2);
            check({t, "_busy"}, be, 0);
            check({t, "_word"}, x0[vecs[v].idx*16 +: 16], vecs[v].exp_word);
            check({t, "_all_words"}, word_errs(vecs[v].base), 0);
            do_ack(t, 1'b0);
        end

        // Hold DONE for 20 cycles, then ack together with a start that must be dropped.
        mode = 0;
        run_load(16'h0200, 1'b0, nr, ae, ec, be);
        snap = x0;
        changes = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (x0 != snap || !en0) changes++;
        end
        check("hold_stable", changes, 0);
        do_ack("ack_start", 1'b1);
        run_load(16'h0300, 1'b0, nr, ae, ec, be);
        check("fresh_nreads", nr, N);
        check("fresh_en_latency", ec, N + 2);
        check("fresh_all_words", word_errs(16'h0300), 0);
        do_ack("fresh", 1'b0);

        // Reset in the middle of a load, then reload with different RAM contents.
        @(negedge clk);
        base0 = 16'h0100;
        cnn0  = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            cnn0 = 1'b0;
            if (c == 60) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        check("midrst_rd_en", rd0, 0);
        check("midrst_busy", busy0, 0);
        check("midrst_en_fc", en0, 0);
        mode = 1;
        run_load(16'h0100, 1'b0, nr, ae, ec, be);
        check("reload_nreads", nr, N);
        check("reload_all_words", word_errs(16'h0100), 0);
        do_ack("reload", 1'b0);

        // Single-word loader.
        mode = 0;
        @(negedge clk);
        base1 = 16'h0042;
        cnn1  = 1'b1;
        @(negedge clk);
        cnn1 = 1'b0;
        check("n1_rd_en_t1", rd1, 1);
        check("n1_addr_t1", addr1, 16'h0042);
        check("n1_busy_t1", busy1, 1);
        @(negedge clk);
        check("n1_rd_en_t2", rd1, 0);
        check("n1_en_t2", en1, 0);
        @(negedge clk);
        check("n1_en_t3", en1, 1);
        check("n1_x_t3", x1, 16'h5A18);
        check("n1_busy_t3", busy1, 0);
        ack1 = 1'b1;
        @(negedge clk);
        ack1 = 1'b0;
        check("n1_en_after_ack", en1, 0);
        check("n1_x_after_ack", x1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
